// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants for the CP0 interrupt path.
//   - irq_state_t : interrupt front-end FSM encodings (2-bit)
//   - EXE_CP0_*   : execute-stage CP0 operation codes
//   - CP0_*       : CP0 register numbers and exception codes
//   - irq_id_w()  : width of a source id, never below 1
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_WAIT = 2'd2,
    IRQ_SERV = 2'd3
  } irq_state_t;

  localparam logic [2:0] EXE_CP0_NONE = 3'd0;
  localparam logic [2:0] EXE_CP0_MFC0 = 3'd1;
  localparam logic [2:0] EXE_CP0_MTC0 = 3'd2;
  localparam logic [2:0] EXE_CP0_ERET = 3'd3;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;
  localparam logic [4:0] CP0_EXC_INT    = 5'd0;

  function automatic int unsigned irq_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// irq_debounce: one interrupt source front-end.
//   clk, rst_n : clock, synchronous active-low reset
//   src        : raw asynchronous line
//   rise       : one-cycle pulse when the debounced level goes 0->1
// A 2-FF synchroniser feeds a counter debouncer; the level is accepted
// once the synchronised value has differed from it for DB_CYCLES+1 samples.
module irq_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             db_lvl;
  logic             lvl_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_lvl <= 1'b0;
      lvl_d  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      lvl_d <= db_lvl;
      if (sync2 == db_lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db_lvl <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = db_lvl & ~lvl_d;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt front-end ahead of CP0.
//   clk, rst_n  : clock, synchronous active-low reset
//   irq_src     : raw async interrupt lines (active-high)
//   irq_mask    : 1 = source may be arbitrated
//   ir_taken    : CP0 took the interrupt this cycle
//   eret        : CP0 executes ERET this cycle
//   ir_req      : one-cycle request pulse to CP0 ir_in
//   irq_id      : id of outstanding / last serviced source
//   irq_pending : latched rising edges awaiting service
//   irq_lost    : sticky, edge arrived while already pending
//   in_service  : an interrupt is outstanding
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int unsigned N_SRC     = 4,
  parameter  int unsigned DB_CYCLES = 16,
  localparam int unsigned ID_W      = irq_id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ir_taken,
  input  logic             eret,
  output logic             ir_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pending,
  output logic [N_SRC-1:0] irq_lost,
  output logic             in_service
);

  irq_state_t       state_q;
  irq_state_t       state_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] lost_q;
  logic [N_SRC-1:0] elig_q;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  win_id;
  logic             found;
  logic             grant;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .src   (irq_src[g]),
      .rise  (rise[g])
    );
  end

  // Lowest eligible index wins. Arbitration works from a registered copy
  // of pending & mask, which gives the two-cycle pending-to-request latency.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig_q[i] && !found) begin
        win_id = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (elig_q != '0) begin
          grant   = 1'b1;
          state_d = IRQ_REQ;
        end
      end
      IRQ_REQ:  state_d = IRQ_WAIT;
      IRQ_WAIT: begin
        if (ir_taken)  state_d = IRQ_SERV;
        else if (eret) state_d = IRQ_IDLE;
      end
      IRQ_SERV: begin
        if (eret) state_d = IRQ_IDLE;
      end
      default:  state_d = IRQ_IDLE;
    endcase
  end

  assign clr = grant ? (N_SRC'(1) << win_id) : '0;

  // A new edge on the granted source in the grant cycle re-sets the bit
  // and is not counted as lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      pend_q  <= '0;
      lost_q  <= '0;
      elig_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      elig_q  <= pend_q & irq_mask;
      pend_q  <= (pend_q & ~clr) | rise;
      lost_q  <= lost_q | (rise & pend_q & ~clr);
      if (grant) id_q <= win_id;
    end
  end

  assign ir_req      = (state_q == IRQ_REQ);
  assign in_service  = (state_q != IRQ_IDLE);
  assign irq_id      = id_q;
  assign irq_pending = pend_q;
  assign irq_lost    = lost_q;

endmodule
